// File: rtl/cons.sv
// Burst accumulator: sums each run of valid bytes into a 4-entry FWFT result FIFO.
// Optional CONS_MAX_EN adds out_max, the largest byte of the burst at the FIFO head.
module cons (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        val,
    input  logic [7:0]  data,
    input  logic        out_rdy,
    output logic        out_val,
    output logic [11:0] out_sum,
    output logic [3:0]  out_cnt,
    output logic        drop
`ifdef CONS_MAX_EN
    ,
    output logic [7:0]  out_max
`endif
);

    typedef enum logic {IDLE, ACC} state_t;

    state_t      state, state_nx;
    logic [11:0] sum, sum_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [12:0] sum_add;
    logic        push;

    logic [11:0] mem_sum [4];
    logic [3:0]  mem_cnt [4];
    logic [1:0]  wptr, rptr;
    logic [2:0]  count;
    logic        pop, full, wr_en;

`ifdef CONS_MAX_EN
    logic [7:0]  mx, mx_nx;
    logic [7:0]  mem_max [4];
`endif

    always_comb begin
        state_nx = state;
        sum_nx   = sum;
        cnt_nx   = cnt;
        push     = 1'b0;
        sum_add  = {1'b0, sum} + {5'b0, data};
`ifdef CONS_MAX_EN
        mx_nx    = mx;
`endif
        case (state)
            IDLE: begin
                if (val) begin
                    sum_nx   = {4'b0, data};
                    cnt_nx   = 4'd1;
                    state_nx = ACC;
`ifdef CONS_MAX_EN
                    mx_nx    = data;
`endif
                end
            end
            ACC: begin
                if (val) begin
                    sum_nx = sum_add[12] ? 12'hfff : sum_add[11:0];
                    cnt_nx = (cnt == 4'hf) ? cnt : cnt + 4'd1;
`ifdef CONS_MAX_EN
                    mx_nx  = (data > mx) ? data : mx;
`endif
                end else begin
                    push     = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            sum   <= '0;
            cnt   <= '0;
`ifdef CONS_MAX_EN
            mx    <= '0;
`endif
        end else begin
            state <= state_nx;
            sum   <= sum_nx;
            cnt   <= cnt_nx;
`ifdef CONS_MAX_EN
            mx    <= mx_nx;
`endif
        end
    end

    assign out_val = (count != 3'd0);
    assign pop     = out_val & out_rdy;
    assign full    = (count == 3'd4);
    // When full, wptr equals rptr, so a same-edge pop frees exactly the slot being written.
    assign wr_en   = push & (~full | pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            drop  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_sum[i] <= '0;
                mem_cnt[i] <= '0;
`ifdef CONS_MAX_EN
                mem_max[i] <= '0;
`endif
            end
        end else begin
            drop <= push & full & ~pop;
            if (wr_en) begin
                mem_sum[wptr] <= sum;
                mem_cnt[wptr] <= cnt;
`ifdef CONS_MAX_EN
                mem_max[wptr] <= mx;
`endif
                wptr <= wptr + 2'd1;
            end
            if (pop)
                rptr <= rptr + 2'd1;
            case ({wr_en, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_sum = mem_sum[rptr];
    assign out_cnt = mem_cnt[rptr];
`ifdef CONS_MAX_EN
    assign out_max = mem_max[rptr];
`endif

endmodule

// File: doc/cons.md
CONS -- requirements
Module: cons

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_b  input  1  asynchronous, active-low reset; one clock domain only.
REQ-003 val  input  1  upstream valid; no backpressure exists toward the producer.
REQ-004 data  input  8  upstream byte; sampled only when val=1, ignored (may be X) otherwise.
REQ-005 out_rdy  input  1  downstream ready for a burst result.
REQ-006 out_val  output  1  result FIFO non-empty.
REQ-007 out_sum  output  12  burst sum at FIFO head.
REQ-008 out_cnt  output  4  burst length at FIFO head.
REQ-009 drop  output  1  one-cycle pulse: a burst result was lost because the FIFO was full.

Function
REQ-010 A burst SHALL be a maximal run of consecutive cycles with val=1, sampled at rising clk edges.
REQ-011 FSM states SHALL be IDLE and ACC; reset state IDLE.
REQ-012 IDLE, val=1: SHALL load sum=data, cnt=1, go to ACC.
REQ-013 IDLE, val=0: SHALL hold; no FIFO write.
REQ-014 ACC, val=1: SHALL add data to sum and increment cnt; stay in ACC.
REQ-015 Sum SHALL saturate at 4095 and cnt SHALL saturate at 15; there is no wrap-around.
REQ-016 ACC, val=0: SHALL write {sum,cnt} to the FIFO on that edge and go to IDLE.
REQ-017 The result FIFO SHALL be 4 entries, first-word-fall-through; out_sum/out_cnt SHALL be driven from registers at the head.
REQ-018 out_val SHALL rise in the cycle after the burst-end edge when the FIFO was empty (1-cycle latency).
REQ-019 A pop SHALL occur on an edge with out_val=1 and out_rdy=1.
REQ-020 out_rdy while out_val=0 SHALL have no effect.
REQ-021 On simultaneous push and pop, occupancy SHALL be unchanged, and the push SHALL be accepted even when the FIFO is full.
REQ-022 A push to a full FIFO without a same-edge pop SHALL be discarded, leave the FIFO contents unchanged, and assert drop for exactly one cycle.
REQ-023 Read/write pointers SHALL be 2-bit, wrap modulo 4, with a 3-bit occupancy count (0..4).
REQ-024 out_sum/out_cnt SHALL be stable while out_val=1 and out_rdy=0.

Reset
REQ-025 rst_b=0 SHALL immediately force the state to IDLE, sum=0, cnt=0, FIFO empty, out_val=0, out_sum=0, out_cnt=0, drop=0.
REQ-026 A reset asserted mid-burst SHALL discard the partial burst; no result is written.
REQ-027 After rst_b deasserts, the first edge with val=1 SHALL start a new burst.

Configuration
REQ-028 Macro CONS_MAX_EN: when defined, the block SHALL add output out_max [7:0] (largest data in the burst, stored per FIFO entry, reset 0, held with the head entry).
REQ-029 When CONS_MAX_EN is not defined, out_max and its storage SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Burst: reset, then val=1 for 3 cycles with data 2,5,1, then val=0, out_rdy=1 -> one cycle after burst end out_val=1, out_sum=8, out_cnt=3; popped next edge; drop stays 0.
REQ-031 Back-to-back: bursts {3},{4,4},{1,0,5,2},{5} separated by single val=0 cycles, out_rdy=0 -> FIFO full (4 entries); a fifth burst {1} -> drop pulses 1 cycle; then out_rdy=1 returns (3,1),(8,2),(8,4),(5,1) in order.
REQ-032 Full plus simultaneous pop: FIFO full, burst {2} ends on an edge with out_rdy=1 -> no drop; head pops; the new entry (2,1) appears last.
REQ-033 Saturation: val=1 for 20 cycles with data=255 -> out_sum=4095, out_cnt=15.
REQ-034 Reset mid-burst: 2 valid cycles, then rst_b low 25 time units, then val=0 -> out_val stays 0 and no entry is written.
REQ-035 With CONS_MAX_EN defined: burst 2,5,1 -> out_max=5.
REQ-036 With CONS_MAX_EN defined and REQ-031 rerun -> out_max reads 3,4,5,5 in order.
